// File: rtl/phase_vec_pkg.sv
// Shared definitions for the phase/frequency vector read path.
// Holds the sequencer state encoding and the default geometry of the
// phase/frequency vector SRAM. There are no ports.

package phase_vec_pkg;

    localparam int PV_DEPTH      = 2048;
    localparam int PV_ADDR_WIDTH = 12;
    localparam int PV_DATA_WIDTH = 16;
    localparam int MAX_PAIRS     = PV_DEPTH / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pv_state_e;

endpackage

// File: rtl/pair_skid_fifo.sv
// pair_skid_fifo: 2-entry first-word-fall-through FIFO for sample pairs.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   flush        discards all stored entries (wins over push)
//   push         write push_data this cycle
//   push_data    incoming pair {even, odd}
//   pop          consumer takes the head this cycle (ignored when !valid)
//   count        number of stored entries (0..2)
//   valid        head is available
//   head         head entry
//
// When the FIFO is empty, an incoming push is presented on head in the same
// cycle. This lets a pair returned by the SRAM reach the consumer in the
// cycle it arrives, which gives one pair per cycle with a single outstanding
// read. A bypassed pair that is not taken is stored and shown again from
// storage, so head stays stable while stalled.

module pair_skid_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             pop_eff;
    logic             bypass;
    logic             store;
    logic             take;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        valid = (count_q != 2'd0) || push;
        if (count_q != 2'd0) begin
            head = mem_q[rd_ptr_q];
        end else if (push) begin
            head = push_data;
        end else begin
            head = '0;
        end

        pop_eff = pop && valid;
        // Pair arrives into an empty FIFO and is consumed immediately.
        bypass  = push && pop_eff && (count_q == 2'd0);
        store   = push && !bypass && (count_q != 2'd2);
        take    = pop_eff && (count_q != 2'd0);

        if (store) begin
            // Write slot is the one after the head (mod 2).
            mem_d[rd_ptr_q ^ count_q[0]] = push_data;
        end
        if (take) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, store} - {1'b0, take};

        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/phase_vec_read_sequencer.sv
// phase_vec_read_sequencer: burst reader for the phase/frequency vector SRAM.
//
// Reads sample pairs using both SRAM read ports in parallel (R port for the
// first address of a pair, R/W port for the second) and hands them to the
// kernel estimator through a 2-entry FWFT FIFO with credit-based issue.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 burst request pulse (accepted in IDLE with load=0)
//   base_adr, num_pairs   burst base address and pair count, sampled on start
//   load                  SRAM loading active; aborts a running burst
//   ren, rwen             read enables to the SRAM interface
//   radr, rwadr           read addresses to the SRAM interface
//   rdata, rwdata         read data, valid one cycle after the enable
//   out_valid, out_ready  pair handshake to the consumer
//   out_even, out_odd     pair samples at base+2k and base+2k+1
//   busy                  burst in progress (RUN or DRAIN)
//   done                  one-cycle pulse at burst end or abort
//   aborted               sticky abort flag, cleared by the next accepted start
//
// state | meaning
// IDLE  | waiting for start with load=0
// RUN   | issuing pair reads while credit allows
// DRAIN | all reads issued, waiting for the last pair to leave the FIFO
// DONE  | done pulse, then back to IDLE

module phase_vec_read_sequencer
    import phase_vec_pkg::*;
#(
    parameter int DATA_WIDTH = PV_DATA_WIDTH,
    parameter int ADDR_WIDTH = PV_ADDR_WIDTH,
    parameter int DEPTH      = PV_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_adr,
    input  logic [ADDR_WIDTH-1:0] num_pairs,
    input  logic                  load,
    output logic                  ren,
    output logic                  rwen,
    output logic [ADDR_WIDTH-1:0] radr,
    output logic [ADDR_WIDTH-1:0] rwadr,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] rwdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_even,
    output logic [DATA_WIDTH-1:0] out_odd,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int                    SUM_W       = ADDR_WIDTH + 1;
    localparam logic [SUM_W-1:0]      DEPTH_S     = SUM_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_PAIRS_A = ADDR_WIDTH'(DEPTH / 2);

    // base < DEPTH and 2k+1 < DEPTH, so one conditional subtract is enough.
    function automatic logic [ADDR_WIDTH-1:0] wrap_adr(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] r;
        r = (s >= DEPTH_S) ? (s - DEPTH_S) : s;
        return ADDR_WIDTH'(r);
    endfunction

    pv_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic                  inflight_q, inflight_d;
    logic                  aborted_q, aborted_d;

    logic [ADDR_WIDTH-1:0] base_mod;
    logic [ADDR_WIDTH-1:0] cnt_sat;
    logic [ADDR_WIDTH-1:0] k_inc;
    logic [SUM_W-1:0]      sum_even;
    logic [SUM_W-1:0]      sum_odd;
    logic [ADDR_WIDTH-1:0] adr_even;
    logic [ADDR_WIDTH-1:0] adr_odd;

    logic [1:0]              fifo_count;
    logic                    fifo_valid;
    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic                    push;
    logic                    pop;
    logic                    abort;
    logic                    issue;
    logic [2:0]              occ;
    logic [2:0]              drain_next;

    assign base_mod = ADDR_WIDTH'({1'b0, base_adr} % DEPTH_S);
    assign cnt_sat  = (num_pairs > MAX_PAIRS_A) ? MAX_PAIRS_A : num_pairs;
    assign k_inc    = k_q + 1'b1;

    assign sum_even = {1'b0, base_q} + {k_q, 1'b0};
    assign sum_odd  = sum_even + 1'b1;
    assign adr_even = wrap_adr(sum_even);
    assign adr_odd  = wrap_adr(sum_odd);

    assign abort = load && ((state_q == RUN) || (state_q == DRAIN));
    // Data returned during an abort cycle is discarded along with the FIFO.
    assign push  = inflight_q && !abort;
    assign pop   = fifo_valid && out_ready;

    // Occupancy once this cycle's pop is taken; one more read may be in
    // flight only if the FIFO can still absorb it next cycle.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == RUN) && !load && (occ < 3'd2);
    assign drain_next = {1'b0, fifo_count} + {2'b00, push} - {2'b00, pop};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        aborted_d  = aborted_q;
        inflight_d = issue;

        case (state_q)
            IDLE: begin
                if (start && !load) begin
                    base_d    = base_mod;
                    cnt_d     = cnt_sat;
                    k_d       = '0;
                    aborted_d = 1'b0;
                    state_d   = (num_pairs == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (issue) begin
                    k_d = k_inc;
                    if (k_inc == cnt_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (drain_next == 3'd0) begin
                    // No read in flight after this edge and FIFO empties now.
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            inflight_q <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            aborted_q  <= aborted_d;
        end
    end

    pair_skid_fifo #(
        .WIDTH (2 * DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .push      (push),
        .push_data ({rdata, rwdata}),
        .pop       (pop),
        .count     (fifo_count),
        .valid     (fifo_valid),
        .head      (fifo_head)
    );

    assign ren       = issue;
    assign rwen      = issue;
    assign radr      = issue ? adr_even : '0;
    assign rwadr     = issue ? adr_odd : '0;
    assign out_valid = fifo_valid;
    assign out_even  = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign out_odd   = fifo_head[DATA_WIDTH-1:0];
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_phase_vec_read_sequencer.sv
// Testbench for phase_vec_read_sequencer: SRAM model plus a per-burst
// reference built from the burst rules (expected address and data lists),
// with randomized bursts, backpressure and start noise.

module tb_phase_vec_read_sequencer;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int D  = 2048;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_adr;
    logic [AW-1:0] num_pairs;
    logic          load;
    logic          ren, rwen;
    logic [AW-1:0] radr, rwadr;
    logic [DW-1:0] rdata, rwdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_even, out_odd;
    logic          busy, done, aborted;

    logic [DW-1:0] mem [D];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    phase_vec_read_sequencer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (D)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_adr  (base_adr),
        .num_pairs (num_pairs),
        .load      (load),
        .ren       (ren),
        .rwen      (rwen),
        .radr      (radr),
        .rwadr     (rwadr),
        .rdata     (rdata),
        .rwdata    (rwdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_even  (out_even),
        .out_odd   (out_odd),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    // SRAM with 1-cycle read latency on both read ports.
    always @(posedge clk) begin
        if (ren)  rdata  <= mem[radr[10:0]];
        if (rwen) rwdata <= mem[rwadr[10:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: out_ready=1; mode 1: ready pattern 1,0,0,...; mode 2: random
    // ready plus ignored start pulses during the burst.
    task automatic run_burst(input logic [AW-1:0] base, input logic [AW-1:0] np,
                             input int mode, input int abort_after);
        int            n;
        int            exp_ra[$];
        int            exp_rwa[$];
        logic [DW-1:0] exp_e[$];
        logic [DW-1:0] exp_o[$];
        int            issued, popped, outstanding;
        int            first_issue, last_issue, first_valid, done_cyc, load_cyc;
        bit            seen_done, did_abort, load_now, prev_stall, prev_load, pop_now;
        logic [DW-1:0] prev_e, prev_o;
        int            budget;

        n = (int'(np) > D / 2) ? D / 2 : int'(np);
        for (int k = 0; k < n; k++) begin
            int a, b;
            a = (int'(base) + 2 * k) % D;
            b = (int'(base) + 2 * k + 1) % D;
            exp_ra.push_back(a);
            exp_rwa.push_back(b);
            exp_e.push_back(mem[11'(a)]);
            exp_o.push_back(mem[11'(b)]);
        end
        issued = 0; popped = 0;
        first_issue = -1; last_issue = -1; first_valid = -1; done_cyc = -1; load_cyc = -1;
        seen_done = 0; did_abort = 0; prev_stall = 0; prev_load = 0;
        prev_e = '0; prev_o = '0;
        budget = 4 * n + 20;

        @(negedge clk);
        start     = 1'b1;
        base_adr  = base;
        num_pairs = np;
        load      = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("busy_before_start", 32'(busy), 0);
        check_eq("ren_before_start", 32'(ren), 0);

        for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode == 2) begin
                start     = 1'($urandom_range(0, 1));
                base_adr  = AW'($urandom);
                num_pairs = AW'($urandom);
            end
            load_now = (abort_after > 0) && !did_abort && (issued == abort_after);
            load     = load_now;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop_now = out_valid && out_ready;

            if (ren || rwen) begin
                check_eq("ren_eq_rwen", 32'(ren), 32'(rwen));
                check_eq("issue_in_range", 32'(issued < n), 1);
                if (issued < n) begin
                    check_eq("radr", 32'(radr), 32'(exp_ra[issued]));
                    check_eq("rwadr", 32'(rwadr), 32'(exp_rwa[issued]));
                end
                outstanding = issued - popped - (pop_now ? 1 : 0);
                check_eq("credit", 32'(outstanding < 2), 1);
                if (first_issue < 0) first_issue = cyc;
                last_issue = cyc;
                issued++;
            end
            if (load_now) begin
                check_eq("no_issue_on_load", 32'(ren || rwen), 0);
                did_abort = 1;
                load_cyc  = cyc;
            end
            if (prev_stall && !prev_load) begin
                check_eq("hold_valid", 32'(out_valid), 1);
                check_eq("hold_even", 32'(out_even), 32'(prev_e));
                check_eq("hold_odd", 32'(out_odd), 32'(prev_o));
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (pop_now) begin
                check_eq("pop_in_range", 32'(popped < n), 1);
                if (popped < n) begin
                    check_eq("out_even", 32'(out_even), 32'(exp_e[popped]));
                    check_eq("out_odd", 32'(out_odd), 32'(exp_o[popped]));
                end
                popped++;
            end
            if (did_abort && cyc == load_cyc + 1) begin
                check_eq("abort_done", 32'(done), 1);
                check_eq("abort_flag", 32'(aborted), 1);
                check_eq("abort_flush", 32'(out_valid), 0);
            end
            if (cyc == 1) check_eq("aborted_cleared", 32'(aborted), 0);
            check_eq("busy", 32'(busy), 32'(n > 0 && !done));

            prev_stall = out_valid && !out_ready;
            prev_e     = out_even;
            prev_o     = out_odd;
            prev_load  = load_now;
            if (done) begin
                seen_done = 1;
                done_cyc  = cyc;
            end
        end

        check_eq("done_seen", 32'(seen_done), 1);
        if (!did_abort) begin
            check_eq("issue_count", 32'(issued), 32'(n));
            check_eq("pop_count", 32'(popped), 32'(n));
        end
        if (mode == 0 && !did_abort && n > 0) begin
            check_eq("first_issue_cyc", 32'(first_issue), 1);
            check_eq("issue_back_to_back", 32'(last_issue - first_issue), 32'(n - 1));
            check_eq("first_valid_lat", 32'(first_valid - first_issue), 1);
            check_eq("done_after_last_issue", 32'(done_cyc - last_issue), 2);
        end
        if (n == 0) begin
            check_eq("zero_done_cyc", 32'(done_cyc), 1);
            check_eq("zero_no_issue", 32'(issued), 0);
        end

        @(negedge clk);
        start     = 1'b0;
        load      = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("done_one_cycle", 32'(done), 0);
        check_eq("busy_after", 32'(busy), 0);
        check_eq("aborted_sticky", 32'(aborted), 32'(did_abort));
        check_eq("ren_after", 32'(ren), 0);
    endtask

    initial begin
        logic          saw_done;
        logic [AW-1:0] rb, rn;

        for (int i = 0; i < D; i++) mem[11'(i)] = 16'(i);
        rst_n     = 1'b0;
        start     = 1'b1;
        base_adr  = 12'd5;
        num_pairs = 12'd3;
        load      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ren", 32'(ren), 0);
        check_eq("rst_rwen", 32'(rwen), 0);
        check_eq("rst_radr", 32'(radr), 0);
        check_eq("rst_rwadr", 32'(rwadr), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_aborted", 32'(aborted), 0);
        check_eq("rst_out_even", 32'(out_even), 0);
        check_eq("rst_out_odd", 32'(out_odd), 0);
        start = 1'b0;
        rst_n = 1'b1;

        run_burst(12'd0, 12'd4, 0, 0);
        run_burst(12'd0, 12'd4, 1, 0);
        run_burst(12'd2046, 12'd2, 0, 0);
        run_burst(12'd2047, 12'd3, 1, 0);
        run_burst(12'd100, 12'd0, 0, 0);

        for (int i = 0; i < D; i++) mem[11'(i)] = 16'($urandom);
        run_burst(12'd10, 12'd3000, 0, 0);

        // load while loading is active must not start a burst
        @(negedge clk);
        start = 1'b1; load = 1'b1; num_pairs = 12'd4;
        @(negedge clk);
        start = 1'b0; load = 1'b0;
        #1;
        check_eq("start_with_load_ignored", 32'(busy), 0);

        run_burst(12'd20, 12'd8, 0, 3);
        run_burst(12'd300, 12'd5, 0, 0);

        for (int t = 0; t < 14; t++) begin
            rb = AW'($urandom);
            rn = (t % 5 == 4) ? 12'd0 : AW'($urandom_range(1, 24));
            run_burst(rb, rn, int'($urandom_range(0, 2)), 0);
        end

        // reset mid-burst: no done pulse, back to reset state
        @(negedge clk);
        start = 1'b1; base_adr = 12'd64; num_pairs = 12'd20; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_ren", 32'(ren), 0);
        check_eq("midrst_valid", 32'(out_valid), 0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check_eq("midrst_no_done", 32'(saw_done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
